writeback_stage: RTL and testbench

Final pipeline stage of the five-stage processor: holds the MEM/WB pipeline register and drives the register-file write port consumed by the decode stage. It selects the write-back value: ALU result, load data, or link PC for `jal`. It suppresses writes to r0 and generates the same-cycle FD bypass flags (`highFD1`/`highFD2`) that decode uses when it reads a register being written in the current cycle. It also supports stall and flush, and an optional retired-instruction counter.

---
 rtl/writeback_stage.sv | 133 +++++++++++++
 tb/tb_writeback_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus register-file write port.
// Selects ALU result, load data or link PC, blocks writes to r0, makes sure
// each instruction writes only once across a stall, and drives the
// same-cycle decode bypass flags.
// Optional feature: define WB_RETIRE_CNT_EN to add the 32-bit 'retired' counter port.
module writeback_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              valid_in,
    input  logic              regWr_in,
    input  logic              m2Reg_in,
    input  logic              jalOp_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  rs1FD,
    input  logic [REG_W-1:0]  rs2FD,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  wb_writeReg,
    output logic [DATA_W-1:0] wbdata_writeReg,
    output logic              highFD1,
    output logic              highFD2
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

    // MEM/WB register fields
    logic              v_reg, rw_reg, m2_reg, jal_reg, done_reg;
    logic [REG_W-1:0]  rd_reg;
    logic [DATA_W-1:0] alu_reg, mem_reg, pc_reg;
    logic              done_next;

    // done records that the held instruction already wrote, so a stall
    // does not repeat the register-file write
    always_comb begin
        done_next = 1'b0;
        if (flush) begin
            done_next = 1'b0;
        end else if (stall) begin
            done_next = done_reg | ctrl_writeEnable;
        end
    end

    // Pipeline register: flush beats stall, stall beats capture
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            v_reg    <= 1'b0;
            rw_reg   <= 1'b0;
            m2_reg   <= 1'b0;
            jal_reg  <= 1'b0;
            rd_reg   <= '0;
            alu_reg  <= '0;
            mem_reg  <= '0;
            pc_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= done_next;
            if (flush) begin
                v_reg  <= 1'b0;
                rw_reg <= 1'b0;
            end else if (!stall) begin
                v_reg   <= valid_in;
                rw_reg  <= regWr_in;
                m2_reg  <= m2Reg_in;
                jal_reg <= jalOp_in;
                rd_reg  <= rd_in;
                alu_reg <= alu_in;
                mem_reg <= mem_in;
                pc_reg  <= pc_in;
            end
        end
    end

    // Write-back select; the r0 check uses the selected index so jal to r0 still links
    always_comb begin
        wb_writeReg     = jal_reg ? LINK_IDX : rd_reg;
        wbdata_writeReg = jal_reg ? pc_reg : (m2_reg ? mem_reg : alu_reg);
        ctrl_writeEnable = v_reg & (rw_reg | jal_reg) & ~done_reg & (wb_writeReg != '0);
    end

    // Same-cycle bypass comparators, one per decode operand
    logic [REG_W-1:0] rs_fd [2];
    logic [1:0]       high_fd;

    assign rs_fd[0] = rs1FD;
    assign rs_fd[1] = rs2FD;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            assign high_fd[gi] = ctrl_writeEnable & (wb_writeReg == rs_fd[gi]);
        end
    endgenerate

    assign highFD1 = high_fd[0];
    assign highFD2 = high_fd[1];

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_reg;
    logic [31:0] retired_next;

    // An instruction retires when it leaves the stage by capture or flush
    always_comb begin
        retired_next = retired_reg;
        if (v_reg && (flush || !stall)) begin
            retired_next = retired_reg + 32'd1;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            retired_reg <= '0;
        end else begin
            retired_reg <= retired_next;
        end
    end

    assign retired = retired_reg;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with an expected-result queue.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        aclr = 1'b0;
    logic        valid_in = 1'b0, regWr_in = 1'b0, m2Reg_in = 1'b0, jalOp_in = 1'b0;
    logic [4:0]  rd_in = '0;
    logic [31:0] alu_in = '0, mem_in = '0, pc_in = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic [4:0]  rs1FD = '0, rs2FD = '0;
    logic        ctrl_writeEnable;
    logic [4:0]  wb_writeReg;
    logic [31:0] wbdata_writeReg;
    logic        highFD1, highFD2;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];

    writeback_stage dut (
        .clock           (clock),
        .aclr            (aclr),
        .valid_in        (valid_in),
        .regWr_in        (regWr_in),
        .m2Reg_in        (m2Reg_in),
        .jalOp_in        (jalOp_in),
        .rd_in           (rd_in),
        .alu_in          (alu_in),
        .mem_in          (mem_in),
        .pc_in           (pc_in),
        .stall           (stall),
        .flush           (flush),
        .rs1FD           (rs1FD),
        .rs2FD           (rs2FD),
        .ctrl_writeEnable(ctrl_writeEnable),
        .wb_writeReg     (wb_writeReg),
        .wbdata_writeReg (wbdata_writeReg),
        .highFD1         (highFD1),
        .highFD2         (highFD2)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retired         (retired)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2, input logic jal,
                          input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] pc);
        valid_in = v; regWr_in = rw; m2Reg_in = m2; jalOp_in = jal;
        rd_in = rd; alu_in = alu; mem_in = mem; pc_in = pc;
    endtask

    task automatic push_raw(input logic we, input logic [4:0] rd, input logic [31:0] data,
                            input logic chk_data);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.chk_data = chk_data;
        exp_q.push_back(e);
    endtask

    // Drive one instruction and queue the result the reference model predicts
    task automatic drive(input logic v, input logic rw, input logic m2, input logic jal,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc);
        logic [4:0]  r;
        logic [31:0] d;
        set_in(v, rw, m2, jal, rd, alu, mem, pc);
        r = jal ? 5'd31 : rd;
        d = jal ? pc : (m2 ? mem : alu);
        push_raw(v & (rw | jal) & (r != 5'd0), r, d, 1'b1);
    endtask

    task automatic pop_check(input string tag, input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        rs1FD = rs1;
        rs2FD = rs2;
        #1;
        $display("txn %s we=%0b reg=%0d data=%h fd1=%0b fd2=%0b", tag, ctrl_writeEnable,
                 wb_writeReg, wbdata_writeReg, highFD1, highFD2);
        chk({tag, "_we"}, {31'd0, ctrl_writeEnable}, {31'd0, e.we});
        if (e.chk_data) begin
            chk({tag, "_reg"}, {27'd0, wb_writeReg}, {27'd0, e.rd});
            chk({tag, "_data"}, wbdata_writeReg, e.data);
        end
        chk({tag, "_fd1"}, {31'd0, highFD1}, {31'd0, e.we & (e.rd == rs1)});
        chk({tag, "_fd2"}, {31'd0, highFD2}, {31'd0, e.we & (e.rd == rs2)});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, {31'd0, ctrl_writeEnable}, 32'd0);
        chk({tag, "_reg"}, {27'd0, wb_writeReg}, 32'd0);
        chk({tag, "_data"}, wbdata_writeReg, 32'd0);
        chk({tag, "_fd1"}, {31'd0, highFD1}, 32'd0);
        chk({tag, "_fd2"}, {31'd0, highFD2}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk({tag, "_retired"}, retired, 32'd0);
`endif
    endtask

    initial begin
        // Reset state
        #1;
        check_all_zero("reset");
        #11;
        aclr = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        // Four valid, one bubble, one valid that is then flushed
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 5'(i + 1), 32'(i + 100), 0, 0);
            tick();
            pop_check("cnt_valid", 0, 0);
        end
        drive(0, 0, 0, 0, 5'd2, 0, 0, 0);
        tick();
        pop_check("cnt_bubble", 0, 0);
        drive(1, 1, 0, 0, 5'd3, 32'h33, 0, 0);
        tick();
        pop_check("cnt_last", 0, 0);
        flush = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        push_raw(0, 0, 0, 0);
        tick();
        flush = 1'b0;
        pop_check("cnt_flush", 0, 0);
        chk("retired_count", retired, 32'd5);
        // Wrap: preload all ones, then one instruction leaves
        drive(1, 1, 0, 0, 5'd4, 32'h44, 0, 0);
        tick();
        pop_check("wrap_load", 0, 0);
        force dut.retired_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_reg;
        chk("retired_preload", retired, 32'hFFFF_FFFF);
        drive(1, 1, 0, 0, 5'd5, 32'h55, 0, 0);
        tick();
        pop_check("wrap_next", 0, 0);
        chk("retired_wrap", retired, 32'd0);
`endif

        // ALU write with operand-A bypass
        drive(1, 1, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0);
        tick();
        pop_check("alu_write", 5, 0);
        // Same source on both operands lights both flags
        drive(1, 1, 0, 0, 5'd6, 32'h66, 32'h0, 32'h0);
        tick();
        pop_check("both_flags", 6, 6);
        // Load select
        drive(1, 1, 1, 0, 5'd3, 32'h10, 32'hBEEF, 32'h0);
        tick();
        pop_check("load_sel", 0, 3);
        // jal with rd_in = 0 links into r31
        drive(1, 0, 0, 1, 5'd0, 32'h10, 32'hBEEF, 32'h40);
        tick();
        pop_check("jal_r0", 31, 1);
        // r0 suppression
        drive(1, 1, 0, 0, 5'd0, 32'h99, 32'h0, 32'h0);
        tick();
        pop_check("r0_supp", 0, 0);
        // Valid but no register write
        drive(1, 0, 0, 0, 5'd12, 32'h99, 32'h0, 32'h0);
        tick();
        pop_check("no_regwr", 12, 12);

        // Stall: write once, then hold with write suppressed
        drive(1, 1, 0, 0, 5'd7, 32'h77, 32'h0, 32'h0);
        tick();
        pop_check("stall_cap", 7, 0);
        stall = 1'b1;
        set_in(1, 1, 0, 0, 5'd8, 32'h88, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            push_raw(0, 5'd7, 32'h77, 1);
            tick();
            pop_check("stall_hold", 7, 7);
        end
        stall = 1'b0;
        drive(1, 1, 0, 0, 5'd8, 32'h88, 32'h0, 32'h0);
        tick();
        pop_check("stall_release", 0, 8);

        // Flush beats stall
        drive(1, 1, 0, 0, 5'd9, 32'h99, 32'h0, 32'h0);
        tick();
        pop_check("flush_cap", 9, 0);
        flush = 1'b1;
        stall = 1'b1;
        push_raw(0, 0, 0, 0);
        tick();
        pop_check("flush_stall", 9, 9);
        flush = 1'b0;
        stall = 1'b0;

        // Asynchronous reset between edges clears outputs at once
        drive(1, 1, 0, 0, 5'd10, 32'hAA, 32'h0, 32'h0);
        tick();
        pop_check("rst_cap", 10, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        aclr = 1'b0;
        #1;
        check_all_zero("async_rst");
        aclr = 1'b1;

        // Reset mid-stall discards the held instruction
        drive(1, 1, 0, 0, 5'd11, 32'hBB, 32'h0, 32'h0);
        tick();
        pop_check("rst_stall_cap", 11, 0);
        stall = 1'b1;
        #1;
        aclr = 1'b0;
        #1;
        aclr = 1'b1;
        push_raw(0, 0, 0, 0);
        tick();
        pop_check("rst_stall_hold", 11, 11);
        stall = 1'b0;

        // Recovery after reset
        drive(1, 1, 0, 0, 5'd13, 32'hCC, 32'h0, 32'h0);
        tick();
        pop_check("post_rst", 13, 13);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
